gray_seq_ctrl: RTL and testbench

Burst controller for the n-bit Gray code generator datapath. It owns the binary step counter and the Gray conversion, and accepts burst commands: start, length, direction, stop, and preload. It streams Gray codes to a consumer over a valid/ready handshake and reports busy, done and wrap status. It sits between the test/control logic and any downstream block consuming Gray sequences.

---
 rtl/gray_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_gray_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: burst controller around an N-bit binary step counter.
// It streams the Gray code of the counter over a valid/ready handshake, and
// handles preload, direction, abort, completion and wrap reporting.
module gray_seq_ctrl #(
  parameter int N     = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             dir,
  input  logic             stop,
  input  logic             load,
  input  logic [N:1]       load_val,
  output logic [N:1]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     bin, bin_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             dir_q, dir_nxt;
  logic             wrap_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N-1:0] gray2bin(input logic [N:1] g);
    logic [N-1:0] b;
    b[N-1] = g[N];
    for (int i = N - 1; i >= 1; i--) begin
      b[i-1] = b[i] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [N:1] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next-state, counter stepping and wrap detection.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_nxt = state;
    bin_nxt   = bin;
    rem_nxt   = rem;
    dir_nxt   = dir_q;
    wrap_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          bin_nxt = gray2bin(load_val);
        end else if (start && (len != '0)) begin
          rem_nxt   = len;
          dir_nxt   = dir;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // out_valid is high for the whole RUN state, so a transfer is out_ready.
        if (out_ready) begin
          rem_nxt = rem - LEN_W'(1);
          if (dir_q) begin
            bin_nxt  = bin - N'(1);
            wrap_nxt = (bin == '0);
          end else begin
            bin_nxt  = bin + N'(1);
            wrap_nxt = (bin == '1);
          end
        end
        // Completion outranks an abort raised in the same cycle.
        if (out_ready && (rem == LEN_W'(1))) begin
          state_nxt = ST_DONE;
        end else if (stop) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they change on the same edge that the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bin       <= '0;
      rem       <= '0;
      dir_q     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      bin       <= bin_nxt;
      rem       <= rem_nxt;
      dir_q     <= dir_nxt;
      out       <= bin2gray(bin_nxt);
      out_valid <= (state_nxt == ST_RUN);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench; the driver pushes expected codes, a
// monitor pops and compares on every handshake.
module tb_gray_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       dir;
  logic       stop;
  logic       load;
  logic [3:1] load_val;
  logic [3:1] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       wrap;

  gray_seq_ctrl #(.N(3), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .dir       (dir),
    .stop      (stop),
    .load      (load),
    .load_val  (load_val),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  int exp_q[$];
  int n_cmp     = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int wrap_cnt  = 0;
  int mbin      = 0;   // model of the counter value as a plain integer 0..7

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  // Inverse found by search rather than by a bit recurrence.
  function automatic int ungray(input int g);
    for (int b = 0; b < 8; b++) if (gray(b) == g) return b;
    return 0;
  endfunction

  function automatic int wrap8(input int v);
    return ((v % 8) + 8) % 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake consumes one expected code.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL xfer_unexpected: got code %0d expected no transfer", out);
        end else begin
          check("xfer_code", int'(out), exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
      if (wrap) wrap_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wrap", int'(wrap), 0);
    exp_q.delete();
    start = 1'b0; load = 1'b0; stop = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mbin = 0;
  endtask

  task automatic do_load(input int g);
    load = 1'b1;
    load_val = 3'(g);
    cycle();
    load = 1'b0;
    check("load_out", int'(out), g);
    check("load_busy", int'(busy), 0);
    mbin = ungray(g);
  endtask

  // One burst from IDLE; mode: 0 ready high, 1 random ready, 2 alternating.
  task automatic run_burst(input int l, input bit d, input int mode,
                           input bit noise, input bit stop_first);
    int b0, wr_exp, dc0, wc0, cyc;
    b0 = mbin;
    wr_exp = 0;
    for (int i = 0; i < l; i++) begin
      int b;
      b = wrap8(d ? b0 - i : b0 + i);
      exp_q.push_back(gray(b));
      if (!d && b == 7) wr_exp++;
      if (d && b == 0) wr_exp++;
    end
    mbin = wrap8(d ? b0 - l : b0 + l);
    dc0 = done_cnt;
    wc0 = wrap_cnt;
    start = 1'b1; len = 8'(l); dir = d;
    cycle();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_valid", int'(out_valid), 1);
    cyc = 0;
    while (!done && cyc < 500) begin
      out_ready = ready_for(mode, cyc);
      stop = stop_first && (cyc == 0);
      if (noise) begin
        load = 1'b1; load_val = 3'($urandom);
        start = 1'b1; len = 8'($urandom); dir = 1'($urandom);
      end
      cycle();
      cyc++;
    end
    stop = noise;   // stop is ignored in the DONE cycle
    check("done_seen", int'(done), 1);
    if (mode == 0) check("done_latency", cyc, l);
    if (mode == 2) check("done_latency_bp", cyc, 2 * l - 1);
    check("done_valid", int'(out_valid), 0);
    check("done_busy", int'(busy), 1);
    check("done_out", int'(out), gray(mbin));
    check("queue_empty", exp_q.size(), 0);
    cycle();
    load = 1'b0; start = 1'b0; stop = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_out", int'(out), gray(mbin));
    check("done_count", done_cnt - dc0, 1);
    check("wrap_count", wrap_cnt - wc0, wr_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; dir = 1'b0; stop = 1'b0;
    load = 1'b0; load_val = '0; out_ready = 1'b1;
    #3;
    check("por_out", int'(out), 0);
    check("por_busy", int'(busy), 0);
    check("por_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a burst, then a short burst from zero.
    for (int i = 0; i < 8; i++) exp_q.push_back(gray(i));
    start = 1'b1; len = 8'd8; dir = 1'b0; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    pulse_reset();
    check("post_rst_busy", int'(busy), 0);
    run_burst(2, 1'b0, 0, 1'b0, 1'b0);

    // Full up-count from reset: one wrap, out back to 000 at done.
    pulse_reset();
    run_burst(8, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure 1,0,1,0,1.
    run_burst(3, 1'b0, 2, 1'b0, 1'b0);

    // Preload 110 and count down.
    do_load(6);
    run_burst(5, 1'b1, 0, 1'b0, 1'b0);
    check("down_end_out", int'(out), 4);

    // Abort in the third RUN cycle.
    do_load(0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    start = 1'b1; len = 8'd8; dir = 1'b0; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    mbin = 3;
    check("stop_valid", int'(out_valid), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    check("stop_out", int'(out), 2);
    check("stop_queue", exp_q.size(), 0);

    // start with len=0 is ignored.
    start = 1'b1; len = 8'd0;
    cycle();
    start = 1'b0;
    check("len0_busy", int'(busy), 0);
    check("len0_valid", int'(out_valid), 0);
    check("len0_out", int'(out), gray(mbin));

    // load and start together: only the load happens.
    load = 1'b1; load_val = 3'b101; start = 1'b1; len = 8'd4;
    cycle();
    load = 1'b0; start = 1'b0;
    mbin = ungray(5);
    check("ldst_out", int'(out), 5);
    check("ldst_busy", int'(busy), 0);
    cycle();
    check("ldst_busy2", int'(busy), 0);

    // Commands while busy are ignored; completion beats stop.
    run_burst(4, 1'b0, 0, 1'b1, 1'b0);
    run_burst(1, 1'b1, 0, 1'b0, 1'b1);

    // Randomized bursts against the model.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 7)));
      run_burst(int'($urandom_range(1, 20)), 1'($urandom), 1,
                1'($urandom), 1'b0);
    end

    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
